// File: rtl/syn_current_accum_if.sv
// Handshake bundle between the spike-event source, the current accumulator and the neuron-update core.
interface syn_current_accum_if #(
  parameter int IDX_W = 4
);
  logic             ev_valid;
  logic             ev_ready;
  logic [IDX_W-1:0] ev_idx;
  logic [16:0]      ev_weight;
  logic             step;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic [16:0]      out_i;
  logic             step_done;
  logic             ev_drop;

  modport master (
    output ev_valid, ev_idx, ev_weight, step, out_ready,
    input  ev_ready, out_valid, out_idx, out_i, step_done, ev_drop
  );

  modport slave (
    input  ev_valid, ev_idx, ev_weight, step, out_ready,
    output ev_ready, out_valid, out_idx, out_i, step_done, ev_drop
  );
endinterface

// File: rtl/syn_current_accum.sv
// Per-neuron saturating Q8.8 synaptic current accumulator with a timestep drain to the neuron core.
// Define SYN_DECAY_EN to halve the accumulators after each drain instead of clearing them.
module syn_current_accum #(
  parameter int N_NEURONS = 16,
  parameter int IDX_W     = 4
) (
  input logic                clk,
  input logic                rst,
  syn_current_accum_if.slave bus
);

  localparam int               DEPTH = 1 << IDX_W;
  localparam logic [IDX_W:0]   N_LIM = (IDX_W+1)'(N_NEURONS);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(N_NEURONS - 1);

  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH} state_t;

  state_t             state;
  logic signed [16:0] acc [DEPTH];
  logic [IDX_W-1:0]   ptr;
  logic               accept;

  // Overflow shows up as the two top bits of the 18-bit sum disagreeing.
  function automatic logic signed [16:0] sat_add(input logic signed [16:0] a,
                                                 input logic signed [16:0] b);
    logic [17:0] s;
    s = {a[16], a} + {b[16], b};
    case (s[17:16])
      2'b01:   return 17'h0FFFF;
      2'b10:   return 17'h10000;
      default: return s[16:0];
    endcase
  endfunction

  assign accept      = bus.ev_valid && bus.ev_ready;
  assign bus.out_idx = ptr;
  assign bus.out_i   = bus.out_valid ? acc[ptr] : 17'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      ptr           <= '0;
      bus.ev_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.step_done <= 1'b0;
      bus.ev_drop   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) acc[i] <= '0;
    end else begin
      bus.step_done <= 1'b0;
      bus.ev_drop   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if ({1'b0, bus.ev_idx} < N_LIM)
              acc[bus.ev_idx] <= sat_add(acc[bus.ev_idx], $signed(bus.ev_weight));
            else
              bus.ev_drop <= 1'b1;
          end
          // An event accepted alongside step lands before the drain reads it.
          if (bus.step) begin
            state         <= DRAIN;
            ptr           <= '0;
            bus.ev_ready  <= 1'b0;
            bus.out_valid <= 1'b1;
          end
        end
        DRAIN: begin
          if (bus.out_ready) begin
            if (ptr == LAST) begin
              state         <= FLUSH;
              ptr           <= '0;
              bus.out_valid <= 1'b0;
              bus.step_done <= 1'b1;
            end else begin
              ptr <= ptr + IDX_W'(1);
            end
          end
        end
        FLUSH: begin
          for (int i = 0; i < DEPTH; i++) begin
`ifdef SYN_DECAY_EN
            acc[i] <= acc[i] >>> 1;
`else
            acc[i] <= '0;
`endif
          end
          state        <= IDLE;
          bus.ev_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_syn_current_accum.sv
// Randomised scoreboard bench for syn_current_accum; the reference model tracks accumulator values
// as plain integers and queues the expected drain sequence whenever a timestep ends.
module tb_syn_current_accum;

  localparam int N  = 16;
  localparam int IW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  syn_current_accum_if #(.IDX_W(IW)) bus();

  syn_current_accum #(.N_NEURONS(N), .IDX_W(IW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [16:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   m_acc[N];
  int   m_phase;
  int   m_left;
  bit   m_drop_pend;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic int clamp(input int v);
    if (v > 65535) return 65535;
    if (v < -65536) return -65536;
    return v;
  endfunction

  // Reference model: 0 = accepting events, 1 = draining, 2 = end-of-step flush cycle.
  always @(negedge clk) begin
    bit nxt_drop;
    int k;
    if (rst) begin
      for (int i = 0; i < N; i++) m_acc[i] = 0;
      m_phase     = 0;
      m_left      = 0;
      m_drop_pend = 1'b0;
      exp_q.delete();
    end else begin
      nxt_drop = 1'b0;
      checkOutput("ev_ready",  32'(bus.ev_ready),  32'(m_phase == 0));
      checkOutput("out_valid", 32'(bus.out_valid), 32'(m_phase == 1));
      checkOutput("step_done", 32'(bus.step_done), 32'(m_phase == 2));
      checkOutput("ev_drop",   32'(bus.ev_drop),   32'(m_drop_pend));
      case (m_phase)
        0: begin
          if (bus.ev_valid) begin
            k = int'(bus.ev_idx);
            if (k < N) m_acc[k] = clamp(m_acc[k] + int'($signed(bus.ev_weight)));
            else nxt_drop = 1'b1;
          end
          if (bus.step) begin
            for (int i = 0; i < N; i++) begin
              exp_q.push_back('{idx: i, val: 17'(m_acc[i])});
`ifdef SYN_DECAY_EN
              m_acc[i] = m_acc[i] >>> 1;
`else
              m_acc[i] = 0;
`endif
            end
            m_phase = 1;
            m_left  = N;
          end
        end
        1: begin
          if (bus.out_ready) begin
            m_left--;
            if (m_left == 0) m_phase = 2;
          end
        end
        default: m_phase = 0;
      endcase
      m_drop_pend = nxt_drop;
    end
  end

  // Monitor: whatever the DUT presents must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_out", 32'(bus.out_idx), 32'hFFFF_FFFF);
      end else begin
        checkOutput("out_idx", 32'(bus.out_idx), 32'(exp_q[0].idx));
        checkOutput("out_i",   32'(bus.out_i),   32'(exp_q[0].val));
        if (bus.out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit v, input int idx, input logic [16:0] w, input bit st);
    bus.ev_valid  = v;
    bus.ev_idx    = IW'(idx);
    bus.ev_weight = w;
    bus.step      = st;
    tick();
    bus.ev_valid = 1'b0;
    bus.step     = 1'b0;
  endtask

  task automatic checkResetValues();
    checkOutput("rst_ev_ready",  32'(bus.ev_ready),  32'd1);
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_step_done", 32'(bus.step_done), 32'd0);
    checkOutput("rst_ev_drop",   32'(bus.ev_drop),   32'd0);
    checkOutput("rst_out_idx",   32'(bus.out_idx),   32'd0);
    checkOutput("rst_out_i",     32'(bus.out_i),     32'd0);
  endtask

  task automatic doReset();
    bus.ev_valid  = 1'b0;
    bus.step      = 1'b0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    checkResetValues();
  endtask

  task automatic drainAll(input bit rnd);
    int  cnt;
    bit  done;
    cnt  = 0;
    done = 1'b0;
    while (!done && cnt < 400) begin
      bus.out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      tick();
      cnt++;
      if (bus.step_done) done = 1'b1;
    end
    bus.out_ready = 1'b1;
    checkOutput("drain_done", 32'(done), 32'd1);
    tick();
  endtask

  task automatic waitIdx(input int t);
    int cnt;
    cnt = 0;
    while (bus.out_idx != IW'(t) && cnt < 64) begin
      tick();
      cnt++;
    end
    checkOutput("wait_idx", 32'(bus.out_idx), 32'(t));
  endtask

  initial begin
    logic [16:0] w;
    int          v;
    bus.ev_valid  = 1'b0;
    bus.ev_idx    = '0;
    bus.ev_weight = '0;
    bus.step      = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    checkResetValues();

    $display("[TB] two events to idx3 then drain");
    applyStimulus(1, 3, 17'h00100, 0);
    applyStimulus(1, 3, 17'h00280, 0);
    applyStimulus(0, 0, 17'h0, 1);
    drainAll(0);

    $display("[TB] positive and negative saturation");
    repeat (300) applyStimulus(1, 0, 17'h00100, 0);
    applyStimulus(0, 0, 17'h0, 1);
    drainAll(0);
    repeat (300) applyStimulus(1, 0, 17'h1FF00, 0);
    applyStimulus(0, 0, 17'h0, 1);
    drainAll(0);

    $display("[TB] event coincident with step");
    doReset();
    applyStimulus(1, 2, 17'h00100, 1);
    drainAll(0);

    $display("[TB] back-pressure at pointer 7");
    applyStimulus(1, 7, 17'h00040, 1);
    waitIdx(7);
    bus.out_ready = 1'b0;
    bus.ev_valid  = 1'b1;
    bus.ev_idx    = IW'(9);
    bus.ev_weight = 17'h00100;
    bus.step      = 1'b1;
    tick();
    bus.step = 1'b0;
    repeat (4) tick();
    bus.ev_valid = 1'b0;
    drainAll(0);

    $display("[TB] flush behaviour over two steps");
    doReset();
    applyStimulus(1, 1, 17'h00300, 0);
    applyStimulus(0, 0, 17'h0, 1);
    drainAll(0);
    applyStimulus(0, 0, 17'h0, 1);
    drainAll(0);

    $display("[TB] out-of-range index dropped");
    applyStimulus(1, 4, 17'h00080, 0);
    applyStimulus(1, 20, 17'h00100, 0);
    applyStimulus(0, 0, 17'h0, 1);
    drainAll(0);

    $display("[TB] reset mid-drain");
    applyStimulus(1, 5, 17'h00500, 0);
    applyStimulus(1, 11, 17'h1F000, 0);
    applyStimulus(0, 0, 17'h0, 1);
    waitIdx(5);
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    checkResetValues();
    repeat (3) tick();
    applyStimulus(0, 0, 17'h0, 1);
    drainAll(0);

    $display("[TB] randomised traffic");
    repeat (6) begin
      repeat (30) begin
        if ($urandom_range(0, 2) == 0) begin
          w = 17'($urandom);
        end else begin
          v = int'($urandom_range(0, 4095)) - 2048;
          w = 17'(v);
        end
        applyStimulus($urandom_range(0, 3) != 0, int'($urandom_range(0, 19)), w, 0);
      end
      applyStimulus($urandom_range(0, 1) == 1, int'($urandom_range(0, 19)), 17'h00100, 1);
      drainAll(1);
    end

    checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
